video_stream_source: RTL and testbench
======================================

Name: video_stream_source

Overview:
- Generates the pixel-stream interface consumed by the maze-processing block: video_frame_valid / video_line_valid / video_data_valid / video_data_out / video_address.
- Pixels come from a frame-buffer read port or from an internal test-pattern generator.
- Drives the processing chain in simulation and in board bring-up without a camera.
- Timing is fully parameterised. Defaults match the 702x288 8-bit grey frame the sink expects.

Parameters:
- H_ACTIVE, 702, pixels per line.
- V_ACTIVE, 288, lines per frame.
- H_BLANK, 16, idle cycles after each line, with line_valid low and frame_valid high.
- F_PRE, 4, cycles with frame_valid high before the first line.
- V_BLANK, 32, cycles with frame_valid low between frames; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request, sampled only at frame boundaries.
- mode  in  2  pixel source: 0 = frame buffer, 1 = horizontal ramp, 2 = checkerboard, 3 = vertical ramp.
- mem_rd  out  1  frame-buffer read strobe.
- mem_addr  out  20  frame-buffer read address.
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd.
- video_frame_valid  out  1  high for the whole frame (F_PRE plus all lines plus H_BLANKs).
- video_line_valid  out  1  high for exactly H_ACTIVE consecutive cycles per line.
- video_data_valid  out  1  identical to video_line_valid; no pixel gaps.
- video_data_out  out  8  pixel value.
- video_address  out  20  linear pixel index, v*H_ACTIVE+h.
- frame_count  out  10  completed frames, wraps 1023 to 0.
- busy  out  1  high from frame start until the end of V_BLANK.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 immediately.
  - FSM goes to IDLE; counters are cleared.
  - Reset mid-frame truncates the frame with no further valid cycles. After release, the next frame starts from pixel 0.
- FSM states: IDLE, PRE, LINE, HBL, VBL.
  - IDLE: all valids 0. When enable=1, latch mode into mode_q, go to PRE, set frame_valid=1 and busy=1.
  - PRE: F_PRE cycles, then go to LINE with v=0, h=0.
  - LINE: H_ACTIVE cycles. Each cycle outputs pixel (h,v) with line_valid=data_valid=1. After h=H_ACTIVE-1, go to HBL.
  - HBL: H_BLANK cycles with line_valid=0 and frame_valid=1. Then:
    - if v<V_ACTIVE-1: increment v and go to LINE;
    - otherwise: set frame_valid=0, increment frame_count, go to VBL.
  - VBL: V_BLANK cycles with all valids 0 and busy=1. Then:
    - if enable=1: re-latch mode_q, go to PRE (back-to-back frames);
    - otherwise: set busy=0 and go to IDLE.
- Frame period with enable held high is F_PRE + V_ACTIVE*(H_ACTIVE+H_BLANK) + V_BLANK cycles.
- Mode and enable changes mid-frame are ignored. Deasserting enable mid-frame lets the current frame complete.
- Pixel pipeline (fixed 1-cycle read latency):
  - Address generation runs one cycle ahead of the output.
  - mem_rd=1 and mem_addr=A in cycle N, in the last PRE/HBL cycle and in LINE cycles except the last.
  - In cycle N+1: data_valid=1, video_address=A, video_data_out=mem_rdata.
  - mem_rd=0 in all other cycles and whenever mode_q≠0.
- Address arithmetic:
  - 20-bit running index: reset to 0 at frame start, +1 per pixel. No multiplier.
  - Final pixel index is H_ACTIVE*V_ACTIVE-1; 202175 at defaults, so it fits in 20 bits.
- Pattern modes, registered with the same one-cycle alignment as mode 0:
  - mode 1: data = h[7:0].
  - mode 2: data = (h[4]^v[4]) ? 8'hFF : 8'h00.
  - mode 3: data = v[7:0].
- Outputs video_data_out and video_address are 0 whenever data_valid=0.
- line_valid and data_valid rise and fall on the same clock edge; line_valid never toggles while frame_valid=0.
- Counter widths: h and v are 10 bits; blanking counters are sized to the largest parameter.

Test Plan (bench uses H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, F_PRE=2, V_BLANK=5, so period = 51):
- Release reset, enable=1, mode=1 held → frame_valid high 46 cycles, low 5; 4 line_valid pulses of 8 cycles each separated by 3; pixels 0..7 every line; addresses 0..31; frame_count 1 after the first frame, 2 after 102 cycles.
- mode=0, memory model returns data = addr XOR 8'h5A with 1-cycle latency → video_data_out at address 9 equals 8'h53; mem_rd pulses total 32 per frame; mem_rd never high when mode≠0.
- mode=2, H_ACTIVE=40 variant → pixels h=0..15 of line 0 are 8'h00 and h=16..31 are 8'hFF; line 16 is inverted.
- enable dropped mid-line 2 → frame completes all 4 lines; after V_BLANK busy=0 and FSM idles; no PRE begins. enable re-raised → next frame_valid rises 1 cycle later.
- mode changed from 1 to 3 mid-frame → current frame keeps the ramp; the next frame outputs v on every pixel of line v.
- reset asserted during line 1 → all outputs are 0 in the same cycle; after release with enable=1, the first pixel has address 0 and frame_count=0.

Source files
------------

// File: rtl/video_stream_source_if.sv
// video_stream_source_if: pixel-stream outputs plus the frame-buffer read port.
interface video_stream_source_if;
    logic        mem_rd;
    logic [19:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        video_frame_valid;
    logic        video_line_valid;
    logic        video_data_valid;
    logic [7:0]  video_data_out;
    logic [19:0] video_address;
    modport master (
        output mem_rd, mem_addr, video_frame_valid, video_line_valid,
               video_data_valid, video_data_out, video_address,
        input  mem_rdata
    );
    modport slave (
        input  mem_rd, mem_addr, video_frame_valid, video_line_valid,
               video_data_valid, video_data_out, video_address,
        output mem_rdata
    );
endinterface

// File: rtl/video_stream_source.sv
// video_stream_source: parameterised frame/line timing generator that streams
// pixels from a frame-buffer read port or a built-in test pattern.
module video_stream_source #(
    parameter int H_ACTIVE = 702,
    parameter int V_ACTIVE = 288,
    parameter int H_BLANK  = 16,
    parameter int F_PRE    = 4,
    parameter int V_BLANK  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    output logic [9:0]                   frame_count,
    output logic                         busy,
    video_stream_source_if.master        bus
);
    localparam int BMAX = (F_PRE > H_BLANK ? (F_PRE > V_BLANK ? F_PRE : V_BLANK)
                                           : (H_BLANK > V_BLANK ? H_BLANK : V_BLANK));
    localparam int CW = $clog2(BMAX + 1);
    typedef enum logic [2:0] {IDLE, PRE, LINE, HBL, VBL} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [9:0]    h, v;
    logic [7:0]    hr, vr, pat, pat_q;
    logic [19:0]   idx, addr_q;
    logic [1:0]    mode_q;
    logic          req, start;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = enable ? PRE : IDLE;
            PRE:     state_n = (cnt == CW'(F_PRE - 1)) ? LINE : PRE;
            LINE:    state_n = (h == 10'(H_ACTIVE - 1)) ? HBL : LINE;
            HBL:     state_n = (cnt != CW'(H_BLANK - 1)) ? HBL : (v == 10'(V_ACTIVE - 1)) ? VBL : LINE;
            VBL:     state_n = (cnt != CW'(V_BLANK - 1)) ? VBL : enable ? PRE : IDLE;
            default: state_n = IDLE;
        endcase
        start = state_n == PRE && state != PRE;
        // Every cycle that leads into LINE fetches the pixel shown next cycle.
        req   = state_n == LINE;
        hr    = (state == LINE) ? h[7:0] + 8'd1 : 8'd0;
        vr    = (state == HBL) ? v[7:0] + 8'd1 : v[7:0];
        pat   = (mode_q == 2'd1) ? hr : (mode_q == 2'd2) ? {8{hr[4] ^ vr[4]}} : vr;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            h           <= '0;
            v           <= '0;
            idx         <= '0;
            addr_q      <= '0;
            pat_q       <= '0;
            mode_q      <= '0;
            frame_count <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
            h     <= (state == LINE && state_n == LINE) ? h + 10'd1 : 10'd0;
            v     <= start ? 10'd0 : (state == HBL && state_n == LINE) ? v + 10'd1 : v;
            idx   <= start ? 20'd0 : req ? idx + 20'd1 : idx;
            if (req) begin
                addr_q <= idx;
                pat_q  <= pat;
            end
            if (start)
                mode_q <= mode;
            if (state == HBL && state_n == VBL)
                frame_count <= frame_count + 10'd1;
        end
    end
    assign bus.video_frame_valid = state == PRE || state == LINE || state == HBL;
    assign bus.video_line_valid  = state == LINE;
    assign bus.video_data_valid  = state == LINE;
    assign bus.video_address     = (state == LINE) ? addr_q : 20'd0;
    assign bus.video_data_out    = (state != LINE) ? 8'd0 : (mode_q == 2'd0) ? bus.mem_rdata : pat_q;
    assign bus.mem_rd            = req && mode_q == 2'd0;
    assign bus.mem_addr          = bus.mem_rd ? idx : 20'd0;
    assign busy                  = state != IDLE;
endmodule

// File: tb/tb_video_stream_source.sv
// tb_video_stream_source: frame-level reference model feeding a pixel scoreboard,
// with a second wide-line instance exercising the checkerboard pattern.
module tb_video_stream_source;
    localparam int H = 8, V = 4, HB = 3, FP = 2, VB = 5;
    localparam int FV = FP + V * (H + HB), P = FV + VB;
    localparam int HW = 40, VW = 20;
    typedef struct {int c; logic [19:0] a; logic [7:0] d;} pix_t;
    logic clk = 0, reset = 0, enable = 0, rst_w = 0, en_w = 0;
    logic [1:0] mode = 0;
    logic [9:0] fc, fc_w;
    logic busy, busy_w;
    int cyc = 0, s_cur = -1000000, next_ok = 0, n_chk = 0, n_fail = 0;
    logic [9:0] fc_e = 0;
    pix_t q[$], q_w[$];
    logic [19:0] exp_rd[int];
    video_stream_source_if bus();
    video_stream_source_if bus_w();
    video_stream_source #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .F_PRE(FP), .V_BLANK(VB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .frame_count(fc), .busy(busy), .bus(bus));
    video_stream_source #(.H_ACTIVE(HW), .V_ACTIVE(VW), .H_BLANK(HB), .F_PRE(FP), .V_BLANK(VB)) dut_w (
        .clk(clk), .reset(rst_w), .enable(en_w), .mode(2'd2),
        .frame_count(fc_w), .busy(busy_w), .bus(bus_w));
    always #5 clk = ~clk;
    // Frame buffer: word at address a holds a ^ 8'h5A, one cycle after the strobe.
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? (bus.mem_addr[7:0] ^ 8'h5A) : 8'hEE;
    assign bus_w.mem_rdata = 8'h00;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input logic [1:0] m, input int hh, input int vv, input logic [19:0] a);
        case (m)
            2'd0:    return a[7:0] ^ 8'h5A;
            2'd1:    return 8'(hh);
            2'd2:    return (((hh >> 4) ^ (vv >> 4)) & 1) != 0 ? 8'hFF : 8'h00;
            default: return 8'(vv);
        endcase
    endfunction

    // Reference model: a frame begins at any edge where enable is seen and the
    // previous frame period has elapsed; its whole pixel schedule is queued then.
    always @(posedge clk) begin
        int t;
        logic [19:0] a;
        cyc++;
        if (!reset) begin
            q.delete();
            exp_rd.delete();
            s_cur = -1000000;
            fc_e = 0;
            next_ok = 0;
        end else begin
            if (cyc == s_cur + FV) fc_e++;
            if (enable && cyc >= next_ok) begin
                s_cur = cyc;
                next_ok = cyc + P;
                for (int vv = 0; vv < V; vv++)
                    for (int hh = 0; hh < H; hh++) begin
                        t = cyc + FP + vv * (H + HB) + hh;
                        a = 20'(vv * H + hh);
                        q.push_back('{t, a, exp_pix(mode, hh, vv, a)});
                        if (mode == 2'd0) exp_rd[t - 1] = a;
                    end
            end
        end
    end

    always @(posedge clk) begin
        int rel;
        logic fv_e, lv_e, busy_e, rd_e;
        logic [27:0] pe;
        logic [19:0] ra_e;
        pix_t p;
        #1;
        rel = cyc - s_cur;
        fv_e = rel >= 0 && rel < FV;
        busy_e = rel >= 0 && rel < P;
        lv_e = fv_e && rel >= FP && ((rel - FP) % (H + HB)) < H;
        while (q.size() != 0 && q[0].c < cyc) void'(q.pop_front());
        pe = '0;
        if (q.size() != 0 && q[0].c == cyc) begin
            p = q.pop_front();
            pe = {p.a, p.d};
        end
        chk("video", 64'({bus.video_frame_valid, bus.video_line_valid, bus.video_data_valid, busy, fc,
                          bus.video_address, bus.video_data_out}),
                     64'({fv_e, lv_e, lv_e, busy_e, fc_e, pe}));
        rd_e = exp_rd.exists(cyc) != 0;
        ra_e = rd_e ? exp_rd[cyc] : 20'd0;
        chk("mem_rd", 64'({bus.mem_rd, bus.mem_rd ? bus.mem_addr : 20'd0}), 64'({rd_e, ra_e}));
    end

    always @(posedge clk) begin
        pix_t p;
        #1;
        chk("w_mem_rd", 64'(bus_w.mem_rd), 64'(0));
        if (bus_w.video_data_valid) begin
            if (q_w.size() == 0)
                chk("w_extra_pixel", 64'(bus_w.video_address), 64'hFFFFF);
            else begin
                p = q_w.pop_front();
                chk("w_pixel", 64'({bus_w.video_address, bus_w.video_data_out}), 64'({p.a, p.d}));
            end
        end
    end

    initial begin
        for (int vv = 0; vv < VW; vv++)
            for (int hh = 0; hh < HW; hh++)
                q_w.push_back('{0, 20'(vv * HW + hh), exp_pix(2'd2, hh, vv, 20'(vv * HW + hh))});
        repeat (3) @(negedge clk);
        reset = 1; rst_w = 1; enable = 1; en_w = 1; mode = 2'd1;
        repeat (50) @(negedge clk);
        en_w = 0;
        repeat (10) @(negedge clk);
        mode = 2'd3;
        repeat (60) @(negedge clk);
        mode = 2'd0;
        repeat (2 * P) @(negedge clk);
        mode = 2'd2;
        repeat (30) @(negedge clk);
        enable = 0;
        repeat (2 * P) @(negedge clk);
        enable = 1;
        mode = 2'd1;
        repeat (P + FP + H + HB + 3) @(negedge clk);
        reset = 0;
        #1;
        chk("reset_zero", 64'({bus.video_frame_valid, bus.video_line_valid, bus.video_data_valid,
                               bus.video_address, bus.video_data_out, bus.mem_rd, bus.mem_addr, fc, busy}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 249) == 0) begin
                reset = 0;
                @(negedge clk);
                reset = 1;
            end
        end
        enable = 0;
        repeat (P + 2) @(negedge clk);
        for (int i = 0; i < 2000 && q_w.size() != 0; i++) @(negedge clk);
        chk("main_queue_drained", 64'(q.size()), 64'(0));
        chk("w_queue_drained", 64'(q_w.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
